memory_arbiter: RTL and testbench

- Shares the core's single external memory port between instruction fetch and the load/store unit.
- Grants one transaction at a time, with data taking priority over fetch.
- Returns read data to the owning requester as a one-cycle valid pulse. Fetch consumes this pulse as instructionData/instructionDataValid.
- Discards fetch responses that a redirect (branch, trap or reset vector) has made stale.

---
 rtl/memory_arbiter_pkg.sv | 50 +++++
 rtl/memory_arbiter.sv | 151 +++++++++++++++
 tb/tb_memory_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for memory_arbiter: arbitration states, the latched
// memory command and the default fetch starvation limit.
package memory_arbiter_pkg;

    // Default number of back-to-back data grants tolerated while fetch waits.
    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

    // Widest address the latched command can carry.
    localparam int unsigned MAX_ADDR_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_REQ,
        FETCH_WAIT,
        DATA_REQ,
        DATA_WAIT,
        DRAIN
    } arbState_;

    typedef struct packed {
        logic                      write;
        logic [MAX_ADDR_WIDTH-1:0] address;
        logic [31:0]               writeData;
        logic [3:0]                byteEnable;
    } memCommand_;

    // Fetches are always full-word reads.
    function automatic memCommand_ fetch_command(input logic [MAX_ADDR_WIDTH-1:0] address);
        memCommand_ cmd;
        cmd.write      = 1'b0;
        cmd.address    = address;
        cmd.writeData  = '0;
        cmd.byteEnable = 4'hF;
        return cmd;
    endfunction

    // Loads ignore the requested lanes and read the whole word.
    function automatic memCommand_ data_command(input logic                      write,
                                                input logic [MAX_ADDR_WIDTH-1:0] address,
                                                input logic [31:0]               writeData,
                                                input logic [3:0]                byteEnable);
        memCommand_ cmd;
        cmd.write      = write;
        cmd.address    = address;
        cmd.writeData  = writeData;
        cmd.byteEnable = write ? byteEnable : 4'hF;
        return cmd;
    endfunction

endpackage

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares the single external memory port between instruction fetch
// and the load/store unit. One transaction outstanding at a time, data has priority,
// stale fetch responses after a redirect are drained silently.
// Optional: define MEMORY_ARBITER_FAIRNESS_EN to force a fetch grant after
// STARVE_LIMIT consecutive data grants made while fetch was waiting.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
    parameter int unsigned ADDR_WIDTH   = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    // Instruction fetch
    input  logic                  fetchRequest,
    input  logic [ADDR_WIDTH-1:0] fetchAddress,
    input  logic                  fetchKill,
    output logic [31:0]           instructionData,
    output logic                  instructionDataValid,
    // Load/store unit
    input  logic                  dataRequest,
    input  logic                  dataWrite,
    input  logic [ADDR_WIDTH-1:0] dataAddress,
    input  logic [31:0]           dataWriteData,
    input  logic [3:0]            dataByteEnable,
    output logic [31:0]           dataReadData,
    output logic                  dataValid,
    // Memory port
    output logic                  memRequest,
    output logic                  memWrite,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [31:0]           memWriteData,
    output logic [3:0]            memByteEnable,
    input  logic                  memReady,
    input  logic                  memResponseValid,
    input  logic [31:0]           memReadData
);

    arbState_   state_q;
    memCommand_ command_q;
    logic       grant_fetch;
    logic       grant_data;
    logic       fetch_forced;

`ifdef MEMORY_ARBITER_FAIRNESS_EN
    localparam int unsigned StarveWidth = $clog2(STARVE_LIMIT + 1);

    logic [StarveWidth-1:0] starve_q;

    assign fetch_forced = (starve_q == StarveWidth'(STARVE_LIMIT));

    // Saturating count of data grants that overtook a waiting fetch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else if (!fetchRequest || grant_fetch) begin
            starve_q <= '0;
        end else if (grant_data && !fetch_forced) begin
            starve_q <= starve_q + StarveWidth'(1);
        end
    end
`else
    assign fetch_forced = 1'b0;
`endif

    // A killed fetch is never granted; a forced fetch overrides data priority.
    assign grant_fetch = (state_q == IDLE) && fetchRequest && !fetchKill &&
                         (!dataRequest || fetch_forced);
    assign grant_data  = (state_q == IDLE) && dataRequest && !grant_fetch;

    assign memWrite      = command_q.write;
    assign memAddress    = command_q.address[ADDR_WIDTH-1:0];
    assign memWriteData  = command_q.writeData;
    assign memByteEnable = command_q.byteEnable;

    // Arbitration FSM with registered command, request and response outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q              <= IDLE;
            command_q            <= '0;
            memRequest           <= 1'b0;
            instructionData      <= '0;
            instructionDataValid <= 1'b0;
            dataReadData         <= '0;
            dataValid            <= 1'b0;
        end else begin
            instructionDataValid <= 1'b0;
            dataValid            <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant_data) begin
                        command_q  <= data_command(dataWrite, MAX_ADDR_WIDTH'(dataAddress),
                                                   dataWriteData, dataByteEnable);
                        memRequest <= 1'b1;
                        state_q    <= DATA_REQ;
                    end else if (grant_fetch) begin
                        command_q  <= fetch_command(MAX_ADDR_WIDTH'(fetchAddress));
                        memRequest <= 1'b1;
                        state_q    <= FETCH_REQ;
                    end
                end
                FETCH_REQ: begin
                    if (fetchKill) begin
                        // Accepted this cycle means a response is still coming.
                        memRequest <= 1'b0;
                        state_q    <= memReady ? DRAIN : IDLE;
                    end else if (memReady) begin
                        memRequest <= 1'b0;
                        state_q    <= FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (memResponseValid) begin
                        if (!fetchKill) begin
                            instructionData      <= memReadData;
                            instructionDataValid <= 1'b1;
                        end
                        state_q <= IDLE;
                    end else if (fetchKill) begin
                        state_q <= DRAIN;
                    end
                end
                DATA_REQ: begin
                    if (memReady) begin
                        memRequest <= 1'b0;
                        state_q    <= DATA_WAIT;
                    end
                end
                DATA_WAIT: begin
                    if (memResponseValid) begin
                        if (!command_q.write) begin
                            dataReadData <= memReadData;
                        end
                        dataValid <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                DRAIN: begin
                    if (memResponseValid) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    memRequest <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter with a small zero/variable-latency
// memory model. Honours MEMORY_ARBITER_FAIRNESS_EN for the starvation scenario.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        fetchRequest, fetchKill;
    logic [31:0] fetchAddress;
    logic [31:0] instructionData;
    logic        instructionDataValid;
    logic        dataRequest, dataWrite;
    logic [31:0] dataAddress, dataWriteData;
    logic [3:0]  dataByteEnable;
    logic [31:0] dataReadData;
    logic        dataValid;
    logic        memRequest, memWrite;
    logic [31:0] memAddress, memWriteData;
    logic [3:0]  memByteEnable;
    logic        memReady = 1'b1;
    logic        memResponseValid = 1'b0;
    logic [31:0] memReadData = '0;

    memory_arbiter #(
        .STARVE_LIMIT(4),
        .ADDR_WIDTH  (32)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .fetchRequest        (fetchRequest),
        .fetchAddress        (fetchAddress),
        .fetchKill           (fetchKill),
        .instructionData     (instructionData),
        .instructionDataValid(instructionDataValid),
        .dataRequest         (dataRequest),
        .dataWrite           (dataWrite),
        .dataAddress         (dataAddress),
        .dataWriteData       (dataWriteData),
        .dataByteEnable      (dataByteEnable),
        .dataReadData        (dataReadData),
        .dataValid           (dataValid),
        .memRequest          (memRequest),
        .memWrite            (memWrite),
        .memAddress          (memAddress),
        .memWriteData        (memWriteData),
        .memByteEnable       (memByteEnable),
        .memReady            (memReady),
        .memResponseValid    (memResponseValid),
        .memReadData         (memReadData)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_mismatches = 0;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_mismatches++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        return a ^ 32'h5A5A_0000;
    endfunction

    // ---------------- memory model ----------------
    int          resp_delay = 0;
    int          stall_left = 0;
    bit          acc_n = 1'b0;
    logic [31:0] acc_data;
    bit          pend = 1'b0;
    int          pend_ctr = 0;
    logic [31:0] pend_data;
    bit          inject_resp = 1'b0;
    logic [31:0] inject_data = '0;

    always @(negedge clock) begin
        acc_n    = memRequest && memReady;
        acc_data = mem_word(memAddress);
    end

    always @(posedge clock) begin
        #1;
        memResponseValid = 1'b0;
        if (reset) begin
            pend  = 1'b0;
            acc_n = 1'b0;
        end
        if (pend) begin
            if (pend_ctr == 0) begin
                memResponseValid = 1'b1;
                memReadData      = pend_data;
                pend             = 1'b0;
            end else begin
                pend_ctr--;
            end
        end
        if (acc_n) begin
            if (resp_delay == 0) begin
                memResponseValid = 1'b1;
                memReadData      = acc_data;
            end else begin
                pend      = 1'b1;
                pend_ctr  = resp_delay - 1;
                pend_data = acc_data;
            end
            acc_n = 1'b0;
        end
        if (inject_resp) begin
            memResponseValid = 1'b1;
            memReadData      = inject_data;
        end
        memReady = (stall_left == 0);
        if (memRequest && stall_left > 0) stall_left--;
    end

    // ---------------- monitor ----------------
    int          ipulses = 0;
    int          dpulses = 0;
    time         ip_time = 0;
    time         dp_time = 0;
    logic        prev_req = 1'b0;
    logic [31:0] grant_log[$];

    always @(negedge clock) begin
        if (!reset) begin
            if (instructionDataValid) begin
                ipulses++;
                ip_time = $time;
            end
            if (dataValid) begin
                dpulses++;
                dp_time = $time;
            end
        end
        if (memRequest && !prev_req) grant_log.push_back(memAddress);
        prev_req = memRequest;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_pulse(input bit instr, input int limit, output int n);
        n = 0;
        for (int i = 0; i < limit; i++) begin
            step();
            n++;
            if (instr ? instructionDataValid : dataValid) break;
        end
    endtask

    function automatic logic [159:0] all_outputs();
        return {24'h0, memRequest, memWrite, memByteEnable, memAddress, memWriteData,
                instructionDataValid, instructionData, dataValid, dataReadData};
    endfunction

    initial begin
        int          n;
        int          base;
        logic [31:0] exp_grant;
        logic [31:0] got_grant;

        fetchRequest   = 1'b0;
        fetchKill      = 1'b0;
        fetchAddress   = '0;
        dataRequest    = 1'b0;
        dataWrite      = 1'b0;
        dataAddress    = '0;
        dataWriteData  = '0;
        dataByteEnable = '0;
        #1 reset = 1'b1;
        repeat (2) step();
        check("reset_outputs", all_outputs(), '0);
        check("reset_state", dut.state_q, IDLE);
        reset = 1'b0;
        step();

        // Fetch only, zero-wait memory
        base         = ipulses;
        fetchRequest = 1'b1;
        fetchAddress = 32'h0000_0100;
        step();
        check("t1_memrequest", memRequest, 1'b1);
        check("t1_command", {memWrite, memByteEnable, memAddress}, {1'b0, 4'hF, 32'h0000_0100});
        wait_pulse(1'b1, 10, n);
        check("t1_latency", n + 1, 3);
        check("t1_data", instructionData, 32'h0050_0093);
        fetchRequest = 1'b0;
        repeat (3) step();
        check("t1_single_pulse", ipulses - base, 1);

        // Fetch and load together: load first, fetch right after
        base           = ipulses;
        fetchRequest   = 1'b1;
        fetchAddress   = 32'h0000_0104;
        dataRequest    = 1'b1;
        dataWrite      = 1'b0;
        dataAddress    = 32'h0000_2000;
        dataByteEnable = 4'h0;
        step();
        check("t2_data_first", {memRequest, memWrite, memByteEnable, memAddress},
              {1'b1, 1'b0, 4'hF, 32'h0000_2000});
        wait_pulse(1'b0, 10, n);
        check("t2_load_latency", n + 1, 3);
        check("t2_load_data", dataReadData, 32'h5A5A_2000);
        check("t2_no_fetch_yet", ipulses - base, 0);
        dataRequest = 1'b0;
        step();
        check("t2_fetch_next", {memRequest, memAddress}, {1'b1, 32'h0000_0104});
        wait_pulse(1'b1, 10, n);
        check("t2_fetch_latency", n + 1, 3);
        check("t2_fetch_data", instructionData, 32'h5A5A_0104);
        check("t2_order", dp_time < ip_time, 1'b1);
        fetchRequest = 1'b0;
        step();

        // Kill in FETCH_WAIT, response 2 cycles later is drained
        base         = ipulses;
        resp_delay   = 2;
        fetchRequest = 1'b1;
        fetchAddress = 32'h0000_0108;
        repeat (2) step();
        check("t3_in_fetch_wait", dut.state_q, FETCH_WAIT);
        fetchKill    = 1'b1;
        fetchRequest = 1'b0;
        step();
        fetchKill = 1'b0;
        check("t3_drain", dut.state_q, DRAIN);
        repeat (2) step();
        check("t3_idle", dut.state_q, IDLE);
        check("t3_no_pulse", ipulses - base, 0);
        resp_delay   = 0;
        fetchRequest = 1'b1;
        fetchAddress = 32'h0000_0200;
        step();
        check("t3_refetch_cmd", {memRequest, memAddress}, {1'b1, 32'h0000_0200});
        wait_pulse(1'b1, 10, n);
        check("t3_refetch_latency", n + 1, 3);
        check("t3_refetch_data", instructionData, 32'h5A5A_0200);
        fetchRequest = 1'b0;
        step();
        check("t3_one_pulse", ipulses - base, 1);

        // Store with memReady low for 3 cycles
        base           = dpulses;
        stall_left     = 3;
        dataRequest    = 1'b1;
        dataWrite      = 1'b1;
        dataAddress    = 32'h0000_3000;
        dataWriteData  = 32'hCAFE_BABE;
        dataByteEnable = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("t4_stable_%0d", i),
                  {memRequest, memWrite, memByteEnable, memAddress, memWriteData},
                  {1'b1, 1'b1, 4'b0011, 32'h0000_3000, 32'hCAFE_BABE});
        end
        step();
        check("t4_req_drop", memRequest, 1'b0);
        wait_pulse(1'b0, 10, n);
        check("t4_ack_latency", n, 1);
        check("t4_readdata_kept", dataReadData, 32'h5A5A_2000);
        dataRequest = 1'b0;
        dataWrite   = 1'b0;
        repeat (2) step();
        check("t4_single_ack", dpulses - base, 1);

        // Continuous data and fetch pressure
        grant_log.delete();
        base         = ipulses + dpulses;
        n            = ipulses;
        dataRequest  = 1'b1;
        dataWrite    = 1'b0;
        dataAddress  = 32'h0000_4000;
        fetchRequest = 1'b1;
        fetchAddress = 32'h0000_0300;
        for (int i = 0; i < 60; i++) begin
            step();
            if (ipulses + dpulses - base >= 6) break;
        end
        dataRequest  = 1'b0;
        fetchRequest = 1'b0;
        check("t5_done", ipulses + dpulses - base, 6);
        for (int i = 0; i < 6; i++) begin
            exp_grant = 32'h0000_4000;
`ifdef MEMORY_ARBITER_FAIRNESS_EN
            if (i == 4) exp_grant = 32'h0000_0300;
`endif
            got_grant = (grant_log.size() > i) ? grant_log[i] : 32'hFFFF_FFFF;
            check($sformatf("t5_grant_%0d", i), got_grant, exp_grant);
        end
`ifdef MEMORY_ARBITER_FAIRNESS_EN
        check("t5_fetch_served", ipulses - n, 1);
`else
        check("t5_fetch_starved", ipulses - n, 0);
`endif
        repeat (2) step();

        // Async reset in DATA_WAIT, late response ignored
        resp_delay  = 3;
        dataRequest = 1'b1;
        dataWrite   = 1'b0;
        dataAddress = 32'h0000_5000;
        repeat (2) step();
        check("t6_in_data_wait", dut.state_q, DATA_WAIT);
        #1 reset = 1'b1;
        #1;
        check("t6_async_outputs", all_outputs(), '0);
        check("t6_async_state", dut.state_q, IDLE);
        dataRequest = 1'b0;
        resp_delay  = 0;
        step();
        reset = 1'b0;
        step();
        base        = ipulses + dpulses;
        inject_data = 32'hBAD0_BAD0;
        inject_resp = 1'b1;
        step();
        inject_resp = 1'b0;
        repeat (2) step();
        check("t6_ignored_pulses", ipulses + dpulses - base, 0);
        check("t6_ignored_state", dut.state_q, IDLE);
        check("t6_ignored_data", {memRequest, dataReadData, instructionData}, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_mismatches);
        $finish;
    end

endmodule
